stream_mux: RTL and testbench

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every channel and on the output. It generalises the fixed-width two-input select muxes in the datapath. It adds three selection modes (fixed priority, round-robin, explicit select), a one-entry output register, and backpressure. It sits between multiple producers (e.g. ALU result, memory read data, immediate path) and a single consumer stage of the multicycle datapath.

---
 rtl/stream_mux.sv | 111 +++++++++++
 tb/tb_stream_mux.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// N-to-1 registered stream mux: fixed-priority, round-robin or explicit-select arbitration.
// 1-cycle latency, one word/cycle; held word stays stable and in_ready is low while out_ready=0.
module stream_mux #(
    parameter int  W    = 8,
    parameter int  N    = 4,
    parameter int  MODE = 0,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);
    logic          r_vld;
    logic [W-1:0]  r_dat;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_ptr;

    logic          w_load;
    logic          w_any;
    logic [SW-1:0] w_gidx;
    logic          w_lo_any;
    logic [SW-1:0] w_lo_idx;
    logic          w_hi_any;
    logic [SW-1:0] w_hi_idx;
    logic          w_sel_any;
    logic [SW-1:0] w_ptr_nxt;
    logic [W-1:0]  w_dat;

    assign w_load = !r_vld || out_ready;

    // lo = lowest valid channel overall; hi = lowest valid channel at or above the rr pointer
    always_comb begin
        w_lo_any  = 1'b0;
        w_lo_idx  = '0;
        w_hi_any  = 1'b0;
        w_hi_idx  = '0;
        w_sel_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_lo_any = 1'b1;
                w_lo_idx = SW'(i);
                if (i >= int'(r_ptr)) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = SW'(i);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
                w_sel_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        if (MODE == 2) begin
            w_any  = w_sel_any;
            w_gidx = w_sel_any ? sel : '0;
        end else if (MODE == 1) begin
            w_any  = w_lo_any;
            w_gidx = w_hi_any ? w_hi_idx : w_lo_idx;
        end else begin
            w_any  = w_lo_any;
            w_gidx = w_lo_idx;
        end
    end

    always_comb begin
        w_dat    = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(w_gidx) == i) begin
                w_dat       = in_data[i*W +: W];
                in_ready[i] = !rst && w_load && w_any;
            end
        end
    end

    assign w_ptr_nxt = (int'(w_gidx) == N - 1) ? '0 : w_gidx + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
            r_sel <= '0;
            r_ptr <= '0;
        end else if (w_load) begin
            r_vld <= w_any;
            if (w_any) begin
                r_dat <= w_dat;
                r_sel <= w_gidx;
                if (MODE == 1) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

    assign out_valid = r_vld;
    assign out_data  = r_dat;
    assign out_sel   = r_sel;
endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: three N=4 instances (modes 0/1/2) on shared inputs plus an N=1, W=13 instance.
module tb_stream_mux;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic [1:0]  c_sel;

    logic [3:0]  a_in_ready, b_in_ready, c_in_ready;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic [7:0]  a_out_data, b_out_data, c_out_data;
    logic [1:0]  a_out_sel, b_out_sel, c_out_sel;

    logic        d_in_valid;
    logic [12:0] d_in_data;
    logic        d_in_ready;
    logic        d_sel;
    logic        d_out_valid;
    logic [12:0] d_out_data;
    logic        d_out_sel;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] sbq[$];
    logic        m_vld[4];
    int          m_ptr;
    int          rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    stream_mux #(.W(8), .N(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .sel(c_sel), .out_valid(a_out_valid), .out_data(a_out_data), .out_sel(a_out_sel),
        .out_ready(out_ready));
    stream_mux #(.W(8), .N(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .sel(c_sel), .out_valid(b_out_valid), .out_data(b_out_data), .out_sel(b_out_sel),
        .out_ready(out_ready));
    stream_mux #(.W(8), .N(4), .MODE(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(c_in_ready),
        .sel(c_sel), .out_valid(c_out_valid), .out_data(c_out_data), .out_sel(c_out_sel),
        .out_ready(out_ready));
    stream_mux #(.W(13), .N(1), .MODE(0)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready),
        .sel(d_sel), .out_valid(d_out_valid), .out_data(d_out_data), .out_sel(d_out_sel),
        .out_ready(out_ready));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] rdy_of(input int m);
        case (m)
            0:       return a_in_ready;
            1:       return b_in_ready;
            2:       return c_in_ready;
            default: return {3'b000, d_in_ready};
        endcase
    endfunction

    function automatic logic vld_of(input int m);
        case (m)
            0:       return a_out_valid;
            1:       return b_out_valid;
            2:       return c_out_valid;
            default: return d_out_valid;
        endcase
    endfunction

    function automatic logic [12:0] dat_of(input int m);
        case (m)
            0:       return {5'b0, a_out_data};
            1:       return {5'b0, b_out_data};
            2:       return {5'b0, c_out_data};
            default: return d_out_data;
        endcase
    endfunction

    function automatic logic [1:0] sel_of(input int m);
        case (m)
            0:       return a_out_sel;
            1:       return b_out_sel;
            2:       return c_out_sel;
            default: return {1'b0, d_out_sel};
        endcase
    endfunction

    // Reference arbitration: which channel each instance should grant given the current inputs.
    function automatic void model_grant(input int m, output logic any, output int idx);
        any = 1'b0;
        idx = 0;
        if (m == 0) begin
            for (int i = 3; i >= 0; i--) if (in_valid[i]) begin any = 1'b1; idx = i; end
        end else if (m == 1) begin
            for (int k = 3; k >= 0; k--) begin
                if (in_valid[(m_ptr + k) % 4]) begin any = 1'b1; idx = (m_ptr + k) % 4; end
            end
        end else if (m == 2) begin
            if (in_valid[c_sel]) begin any = 1'b1; idx = int'(c_sel); end
        end else begin
            any = d_in_valid;
        end
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 4; m++) m_vld[m] = 1'b0;
        m_ptr = 0;
        sbq.delete();
    endtask

    task automatic push(input int m, input int idx);
        logic [1:0]  mm;
        logic [1:0]  ss;
        logic [12:0] dd;
        mm = m[1:0];
        ss = idx[1:0];
        dd = (m < 3) ? {5'b0, in_data[idx*8 +: 8]} : d_in_data;
        sbq.push_back({mm, ss, dd});
    endtask

    task automatic pop_check(input int m);
        int          k;
        logic [16:0] e;
        logic [1:0]  mm;
        k  = -1;
        mm = m[1:0];
        foreach (sbq[i]) if (k < 0 && sbq[i][16:15] == mm) k = i;
        chk($sformatf("sb_has_entry[%0d]", m), {31'b0, (k >= 0)}, 32'd1);
        if (k >= 0) begin
            e = sbq[k];
            chk($sformatf("sb_data[%0d]", m), {19'b0, dat_of(m)}, {19'b0, e[12:0]});
            chk($sformatf("sb_sel[%0d]", m), {30'b0, sel_of(m)}, {30'b0, e[14:13]});
            sbq.delete(k);
        end
    endtask

    // Inputs are driven before calling; check handshakes, score the edge, return at next negedge.
    task automatic step();
        logic any;
        int   idx;
        logic ld;
        #1;
        for (int m = 0; m < 4; m++) begin
            model_grant(m, any, idx);
            ld = !m_vld[m] || out_ready;
            chk($sformatf("in_ready[%0d]", m), {28'b0, rdy_of(m)}, (any && ld) ? (32'd1 << idx) : 32'd0);
            chk($sformatf("out_valid[%0d]", m), {31'b0, vld_of(m)}, {31'b0, m_vld[m]});
            if (m_vld[m] && out_ready) pop_check(m);
            if (any && ld) begin
                push(m, idx);
                m_vld[m] = 1'b1;
                if (m == 1) m_ptr = (idx + 1) % 4;
            end else if (ld) begin
                m_vld[m] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'hF; in_data = 32'h0; out_ready = 1'b1; c_sel = 2'd2;
        d_in_valid = 1'b1; d_in_data = 13'h0; d_sel = 1'b0;
        model_reset();
        #7;
        chk("rst_a_in_ready", {28'b0, a_in_ready}, 32'h0);
        chk("rst_b_in_ready", {28'b0, b_in_ready}, 32'h0);
        chk("rst_d_in_ready", {31'b0, d_in_ready}, 32'h0);
        chk("rst_a_out_valid", {31'b0, a_out_valid}, 32'h0);
        chk("rst_a_out_data", {24'b0, a_out_data}, 32'h0);
        chk("rst_b_out_sel", {30'b0, b_out_sel}, 32'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 4'h0; d_in_valid = 1'b0;

        // Fixed priority: ch1 beats ch3, then ch3 once ch1 drops
        in_valid = 4'b1010; in_data = 32'h33221100;
        step();
        chk("fp_a_data1", {24'b0, a_out_data}, 32'h11);
        chk("fp_a_sel1", {30'b0, a_out_sel}, 32'd1);
        in_valid = 4'b1000;
        step();
        chk("fp_a_data3", {24'b0, a_out_data}, 32'h33);
        chk("fp_a_sel3", {30'b0, a_out_sel}, 32'd3);
        in_valid = 4'h0;
        step();

        // Round-robin with every channel requesting
        in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rr_b_sel%0d", i), {30'b0, b_out_sel}, rr_exp[i]);
            chk($sformatf("rr_a_sel%0d", i), {30'b0, a_out_sel}, 32'd0);
        end

        // Backpressure on the round-robin instance
        in_data = 32'h33A51100;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_b_data", {24'b0, b_out_data}, 32'hA5);
            chk("bp_b_sel", {30'b0, b_out_sel}, 32'd2);
            chk("bp_b_in_ready", {28'b0, b_in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_b_release_rdy", {28'b0, b_in_ready}, 32'h8);
        step();
        chk("bp_b_next_sel", {30'b0, b_out_sel}, 32'd3);

        // Explicit select
        c_sel = 2'd2; in_valid = 4'hF;
        #1;
        chk("es_c_in_ready", {28'b0, c_in_ready}, 32'h4);
        step();
        chk("es_c_sel", {30'b0, c_out_sel}, 32'd2);
        in_valid = 4'b1011;
        step();
        chk("es_c_drained", {31'b0, c_out_valid}, 32'd0);
        in_valid = 4'hF;
        step();
        out_ready = 1'b0; c_sel = 2'd0;
        step();
        chk("es_c_sel_held", {30'b0, c_out_sel}, 32'd2);
        out_ready = 1'b1;
        step();
        chk("es_c_sel_new", {30'b0, c_out_sel}, 32'd0);

        // Asynchronous reset between edges with words held
        in_data = 32'h44332211; d_in_valid = 1'b1; d_in_data = 13'h0ABC;
        step();
        chk("rm_a_data_pre", {24'b0, a_out_data}, 32'h11);
        #2 rst = 1'b1;
        #1;
        chk("rm_a_valid", {31'b0, a_out_valid}, 32'd0);
        chk("rm_a_data", {24'b0, a_out_data}, 32'd0);
        chk("rm_a_sel", {30'b0, a_out_sel}, 32'd0);
        chk("rm_c_sel", {30'b0, c_out_sel}, 32'd0);
        chk("rm_a_in_ready", {28'b0, a_in_ready}, 32'h0);
        chk("rm_d_in_ready", {31'b0, d_in_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("rm_b_in_ready", {28'b0, b_in_ready}, 32'h0);
        chk("rm_b_valid", {31'b0, b_out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
        chk("rm_b_first_sel", {30'b0, b_out_sel}, 32'd0);
        chk("rm_b_first_data", {24'b0, b_out_data}, 32'h11);

        // N=1 drain
        in_valid = 4'h0; d_in_valid = 1'b1; d_in_data = 13'h1FFF;
        step();
        d_in_valid = 1'b0;
        chk("n1_valid", {31'b0, d_out_valid}, 32'd1);
        chk("n1_data", {19'b0, d_out_data}, 32'h1FFF);
        chk("n1_sel", {31'b0, d_out_sel}, 32'd0);
        step();
        chk("n1_drained", {31'b0, d_out_valid}, 32'd0);
        chk("n1_data_held", {19'b0, d_out_data}, 32'h1FFF);

        // Random traffic scored against the reference
        for (int i = 0; i < 80; i++) begin
            in_valid   = 4'($urandom);
            in_data    = $urandom;
            out_ready  = ($urandom_range(0, 3) != 0);
            c_sel      = 2'($urandom);
            d_in_valid = 1'($urandom);
            d_in_data  = 13'($urandom);
            d_sel      = 1'($urandom);
            step();
        end
        in_valid = 4'h0; d_in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("sb_drained", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
